// File: rtl/iguana_fixture.sv
// Test fixture sequencer: chip reset, HyperRAM power-up wait, optional preload
// kick-off, then waits for the end-of-computation write or a global timeout.
module iguana_fixture #(
    parameter int unsigned RST_CYCLES     = 16,
    parameter int unsigned PWRUP_CYCLES   = 60000,
    parameter int unsigned PWRUP_ITVS     = 5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  boot_mode_i,
    input  logic [1:0]  preload_mode_i,
    input  logic        preload_done_i,
    input  logic        eoc_valid_i,
    input  logic [31:0] eoc_data_i,
    output logic        chip_rst_o,
    output logic [1:0]  boot_mode_o,
    output logic [2:0]  preload_start_o,
    output logic        progress_o,
    output logic [2:0]  progress_idx_o,
    output logic [31:0] exit_code_o,
    output logic        done_o,
    output logic        error_o,
    output logic        timeout_o
);

    localparam int unsigned ITV_LEN = PWRUP_CYCLES / PWRUP_ITVS;
    localparam int unsigned PH_MAX  = (RST_CYCLES > PWRUP_CYCLES) ? RST_CYCLES : PWRUP_CYCLES;
    localparam int unsigned PW      = $clog2(PH_MAX + 1);
    localparam int unsigned IW      = $clog2(ITV_LEN + 1);
    localparam int unsigned CW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] RST_LAST   = PW'(RST_CYCLES - 1);
    localparam logic [PW-1:0] PWRUP_LAST = PW'(PWRUP_CYCLES - 1);
    localparam logic [IW-1:0] ITV_LAST   = IW'(ITV_LEN - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    ITVS_MAX   = 3'(PWRUP_ITVS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHIPRST,
        S_PWRUP,
        S_PRELOAD,
        S_WAITLD,
        S_WAITEOC,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    logic [1:0]    preload_mode;
    logic [PW-1:0] ph_cnt;
    logic [IW-1:0] itv_cnt;
    logic [CW-1:0] cyc_cnt;
    logic          run_active;

    // The run clock only ticks between start and a terminal state.
    assign run_active = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);

    // NOTE: all state lives in one clocked block with non-blocking assignments,
    // so every branch below reads the values from before this edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= S_IDLE;
            preload_mode    <= 2'd0;
            ph_cnt          <= '0;
            itv_cnt         <= '0;
            cyc_cnt         <= '0;
            chip_rst_o      <= 1'b1;
            boot_mode_o     <= 2'd0;
            preload_start_o <= 3'b000;
            progress_o      <= 1'b0;
            progress_idx_o  <= 3'd0;
            exit_code_o     <= 32'd0;
            done_o          <= 1'b0;
            error_o         <= 1'b0;
            timeout_o       <= 1'b0;
        end else begin
            progress_o      <= 1'b0;
            preload_start_o <= 3'b000;

            if (run_active && cyc_cnt == TO_LAST) begin
                // Timeout wins over anything else happening on this edge.
                timeout_o <= 1'b1;
                error_o   <= 1'b1;
                state     <= S_ERROR;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            boot_mode_o    <= boot_mode_i;
                            preload_mode   <= preload_mode_i;
                            ph_cnt         <= '0;
                            itv_cnt        <= '0;
                            cyc_cnt        <= '0;
                            chip_rst_o     <= 1'b1;
                            progress_idx_o <= 3'd0;
                            exit_code_o    <= 32'd0;
                            done_o         <= 1'b0;
                            error_o        <= 1'b0;
                            timeout_o      <= 1'b0;
                            state          <= S_CHIPRST;
                        end
                    end

                    S_CHIPRST: begin
                        if (ph_cnt == RST_LAST) begin
                            ph_cnt     <= '0;
                            itv_cnt    <= '0;
                            chip_rst_o <= 1'b0;
                            state      <= S_PWRUP;
                        end else begin
                            ph_cnt <= ph_cnt + PW'(1);
                        end
                    end

                    S_PWRUP: begin
                        ph_cnt <= ph_cnt + PW'(1);
                        if (itv_cnt == ITV_LAST) begin
                            itv_cnt <= '0;
                            if (progress_idx_o < ITVS_MAX) begin
                                progress_o     <= 1'b1;
                                progress_idx_o <= progress_idx_o + 3'd1;
                            end
                        end else begin
                            itv_cnt <= itv_cnt + IW'(1);
                        end

                        if (ph_cnt == PWRUP_LAST) begin
                            case (boot_mode_o)
                                2'd0: begin
                                    if (preload_mode == 2'd3) begin
                                        error_o <= 1'b1;
                                        state   <= S_ERROR;
                                    end else begin
                                        preload_start_o <= 3'b001 << preload_mode;
                                        state           <= S_PRELOAD;
                                    end
                                end
                                2'd1: begin
                                    error_o <= 1'b1;
                                    state   <= S_ERROR;
                                end
                                default: state <= S_WAITEOC;
                            endcase
                        end
                    end

                    S_PRELOAD: state <= S_WAITLD;

                    S_WAITLD: begin
                        if (preload_done_i) begin
                            state <= S_WAITEOC;
                        end
                    end

                    S_WAITEOC: begin
                        if (eoc_valid_i && eoc_data_i[0]) begin
                            exit_code_o <= {1'b0, eoc_data_i[31:1]};
                            done_o      <= 1'b1;
                            state       <= S_DONE;
                        end
                    end

                    S_DONE:  state <= S_DONE;
                    S_ERROR: state <= S_ERROR;
                    default: state <= S_IDLE;
                endcase
            end

            if (run_active) begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_iguana_fixture.sv
// Self-checking bench for iguana_fixture: planned/random stimulus per run,
// expected outputs derived from event times computed with plain arithmetic.
`timescale 1ns/1ps
module tb_iguana_fixture;

    localparam int RST  = 4;
    localparam int PWR  = 23;
    localparam int ITVS = 5;
    localparam int TO   = 200;
    localparam int ITV  = PWR / ITVS;
    localparam int T1   = RST + PWR;
    localparam int NMAX = TO + 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  boot_mode_i = 2'd0;
    logic [1:0]  preload_mode_i = 2'd0;
    logic        preload_done_i = 1'b0;
    logic        eoc_valid_i = 1'b0;
    logic [31:0] eoc_data_i = 32'd0;
    logic        chip_rst_o;
    logic [1:0]  boot_mode_o;
    logic [2:0]  preload_start_o;
    logic        progress_o;
    logic [2:0]  progress_idx_o;
    logic [31:0] exit_code_o;
    logic        done_o;
    logic        error_o;
    logic        timeout_o;

    always #5 clk_i = ~clk_i;

    iguana_fixture #(
        .RST_CYCLES(RST),
        .PWRUP_CYCLES(PWR),
        .PWRUP_ITVS(ITVS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .start_i(start_i),
        .boot_mode_i(boot_mode_i),
        .preload_mode_i(preload_mode_i),
        .preload_done_i(preload_done_i),
        .eoc_valid_i(eoc_valid_i),
        .eoc_data_i(eoc_data_i),
        .chip_rst_o(chip_rst_o),
        .boot_mode_o(boot_mode_o),
        .preload_start_o(preload_start_o),
        .progress_o(progress_o),
        .progress_idx_o(progress_idx_o),
        .exit_code_o(exit_code_o),
        .done_o(done_o),
        .error_o(error_o),
        .timeout_o(timeout_o)
    );

    int errors = 0;
    int checks = 0;

    // Stimulus plan, indexed by the edge number after start that samples it.
    bit          ld_p [0:NMAX];
    bit          ev_p [0:NMAX];
    logic [31:0] ed_p [0:NMAX];
    bit          st_p [0:NMAX];

    int         n_pre;
    int         n_prog;
    logic [2:0] pre_seen;

    task automatic clear_plan();
        for (int i = 0; i <= NMAX; i++) begin
            ld_p[i] = 1'b0;
            ev_p[i] = 1'b0;
            ed_p[i] = 32'd0;
            st_p[i] = 1'b0;
        end
    endtask

    task automatic run_scenario(input logic [1:0] bm, input logic [1:0] pm,
                                input int rst_at, input bit pre_rst);
        bit          bad;
        bit          to_case;
        bit          exp_prog;
        bit          exp_done;
        bit          exp_err;
        bit          exp_to;
        int          t_ld;
        int          t_we;
        int          t_done;
        int          t_err;
        logic [4:0]  exp_flags;
        logic [4:0]  got_flags;
        logic [2:0]  exp_idx;
        logic [2:0]  exp_pre;
        logic [31:0] exp_exit;
        logic [1:0]  exp_bm;

        t_ld = -1; t_we = -1; t_done = -1; t_err = -1; to_case = 1'b0;
        bad = (bm == 2'd1) || (bm == 2'd0 && pm == 2'd3);
        if (bad) begin
            t_err = T1;
        end else begin
            if (bm == 2'd0) begin
                for (int n = T1 + 2; n < TO; n++)
                    if (ld_p[n] && t_ld < 0) t_ld = n;
                t_we = t_ld;
            end else begin
                t_we = T1;
            end
            if (t_we >= 0)
                for (int m = t_we + 1; m < TO; m++)
                    if (ev_p[m] && ed_p[m][0] && t_done < 0) t_done = m;
            if (t_done < 0) begin
                t_err   = TO;
                to_case = 1'b1;
            end
        end

        n_pre = 0; n_prog = 0; pre_seen = 3'b000;
        if (pre_rst) begin
            @(negedge clk_i);
            rst_i = 1'b1; start_i = 1'b0; preload_done_i = 1'b0; eoc_valid_i = 1'b0;
        end
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b1; boot_mode_i = bm; preload_mode_i = pm;
        preload_done_i = 1'b0; eoc_valid_i = 1'b0;

        for (int n = 1; n <= NMAX; n++) begin
            @(negedge clk_i);
            rst_i          = (n == rst_at);
            start_i        = st_p[n];
            boot_mode_i    = 2'($urandom_range(0, 3));
            preload_mode_i = 2'($urandom_range(0, 3));
            preload_done_i = ld_p[n];
            eoc_valid_i    = ev_p[n];
            eoc_data_i     = ed_p[n];
            @(posedge clk_i);
            #1;

            exp_prog = 1'b0;
            exp_idx  = 3'd0;
            for (int k = 1; k <= ITVS; k++) begin
                if (n == RST + k * ITV) exp_prog = 1'b1;
                if (n >= RST + k * ITV) exp_idx = exp_idx + 3'd1;
            end
            exp_done = (t_done >= 0) && (n >= t_done);
            exp_err  = (t_err >= 0) && (n >= t_err);
            exp_to   = to_case && (n >= TO);
            exp_exit = 32'd0;
            if (exp_done) exp_exit = ed_p[t_done] >> 1;
            exp_pre  = (bm == 2'd0 && !bad && n == T1) ? (3'b001 << pm) : 3'b000;
            exp_bm   = bm;
            exp_flags = {(n < RST), exp_prog, exp_done, exp_err, exp_to};
            if (n == rst_at) begin
                exp_flags = 5'b10000;
                exp_idx   = 3'd0;
                exp_pre   = 3'b000;
                exp_exit  = 32'd0;
                exp_bm    = 2'd0;
            end

            got_flags = {chip_rst_o, progress_o, done_o, error_o, timeout_o};
            n_pre    += (preload_start_o != 3'b000) ? 1 : 0;
            n_prog   += progress_o ? 1 : 0;
            pre_seen |= preload_start_o;

            checks++;
            if (got_flags !== exp_flags) begin
                errors++;
                $display("FAIL flags n=%0d bm=%0d pm=%0d: got %b want %b (chip_rst,progress,done,error,timeout)",
                         n, bm, pm, got_flags, exp_flags);
            end
            checks++;
            if (progress_idx_o !== exp_idx) begin
                errors++;
                $display("FAIL progress_idx n=%0d: got %0d want %0d", n, progress_idx_o, exp_idx);
            end
            checks++;
            if (preload_start_o !== exp_pre) begin
                errors++;
                $display("FAIL preload_start n=%0d: got %b want %b", n, preload_start_o, exp_pre);
            end
            checks++;
            if (exit_code_o !== exp_exit) begin
                errors++;
                $display("FAIL exit_code n=%0d: got %h want %h", n, exit_code_o, exp_exit);
            end
            checks++;
            if (boot_mode_o !== exp_bm) begin
                errors++;
                $display("FAIL boot_mode n=%0d: got %0d want %0d", n, boot_mode_o, exp_bm);
            end
            if (n == rst_at) break;
        end
        start_i = 1'b0; preload_done_i = 1'b0; eoc_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [44:0] got;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            rst_i = (i < 2);
            start_i = 1'b0;
            boot_mode_i = 2'd3;
            preload_mode_i = 2'd2;
            eoc_valid_i = 1'b1;
            eoc_data_i = 32'hFFFF_FFFF;
            preload_done_i = 1'b1;
            @(posedge clk_i);
            #1;
            got = {chip_rst_o, boot_mode_o, preload_start_o, progress_o, progress_idx_o,
                   exit_code_o, done_o, error_o, timeout_o};
            checks++;
            if (got !== {1'b1, 44'd0}) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d: got %h want %h", i, got, {1'b1, 44'd0});
            end
        end
        eoc_valid_i = 1'b0;
        preload_done_i = 1'b0;
    endtask

    task automatic test_preload_jtag();
        clear_plan();
        ld_p[T1 + 11] = 1'b1;
        ev_p[T1 + 5]  = 1'b1; ed_p[T1 + 5]  = 32'h0000_0009;
        ev_p[T1 + 20] = 1'b1; ed_p[T1 + 20] = 32'h0000_0001;
        ld_p[10] = 1'b1;
        run_scenario(2'd0, 2'd0, 0, 1'b1);
        checks++;
        if (n_pre !== 1 || pre_seen !== 3'b001) begin
            errors++;
            $display("FAIL jtag_pulse: got %0d pulses mask %b want 1 pulses mask 001", n_pre, pre_seen);
        end
        checks++;
        if (n_prog !== ITVS) begin
            errors++;
            $display("FAIL progress_count: got %0d want %0d", n_prog, ITVS);
        end
        checks++;
        if ({done_o, error_o, exit_code_o} !== {1'b1, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL jtag_done: got done=%b error=%b exit=%h want done=1 error=0 exit=0",
                     done_o, error_o, exit_code_o);
        end
    endtask

    task automatic test_autonomous();
        clear_plan();
        ev_p[T1 - 3] = 1'b1; ed_p[T1 - 3] = 32'h0000_0011;
        ev_p[T1 + 2] = 1'b1; ed_p[T1 + 2] = 32'h0000_0040;
        ev_p[T1 + 6] = 1'b1; ed_p[T1 + 6] = 32'h0000_0007;
        run_scenario(2'd2, 2'd1, 0, 1'b1);
        checks++;
        if (n_pre !== 0 || done_o !== 1'b1 || exit_code_o !== 32'd3) begin
            errors++;
            $display("FAIL autonomous: got pulses=%0d done=%b exit=%h want pulses=0 done=1 exit=3",
                     n_pre, done_o, exit_code_o);
        end
        clear_plan();
        ev_p[T1 + 1] = 1'b1; ed_p[T1 + 1] = 32'hFFFF_FFFF;
        run_scenario(2'd3, 2'd3, 0, 1'b1);
        checks++;
        if (exit_code_o !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL autonomous_max_exit: got %h want 7fffffff", exit_code_o);
        end
    endtask

    task automatic test_sd_error();
        clear_plan();
        ev_p[T1 + 3] = 1'b1; ed_p[T1 + 3] = 32'h0000_0001;
        ld_p[T1 + 4] = 1'b1;
        run_scenario(2'd1, 2'd0, 0, 1'b1);
        checks++;
        if (error_o !== 1'b1 || done_o !== 1'b0 || timeout_o !== 1'b0 || n_pre !== 0) begin
            errors++;
            $display("FAIL sd_error: got error=%b done=%b timeout=%b pulses=%0d want 1 0 0 0",
                     error_o, done_o, timeout_o, n_pre);
        end
    endtask

    task automatic test_preload_modes();
        clear_plan();
        run_scenario(2'd0, 2'd3, 0, 1'b1);
        checks++;
        if (error_o !== 1'b1 || n_pre !== 0) begin
            errors++;
            $display("FAIL reserved_preload: got error=%b pulses=%0d want error=1 pulses=0", error_o, n_pre);
        end
        clear_plan();
        ld_p[T1 + 3] = 1'b1;
        ev_p[T1 + 8] = 1'b1; ed_p[T1 + 8] = 32'h0000_0105;
        run_scenario(2'd0, 2'd2, 0, 1'b1);
        checks++;
        if (pre_seen !== 3'b100 || n_pre !== 1 || exit_code_o !== 32'h82) begin
            errors++;
            $display("FAIL uart_preload: got mask=%b pulses=%0d exit=%h want 100 1 82",
                     pre_seen, n_pre, exit_code_o);
        end
    endtask

    task automatic test_timeout();
        clear_plan();
        run_scenario(2'd0, 2'd1, 0, 1'b1);
        checks++;
        if ({timeout_o, error_o, done_o} !== 3'b110 || pre_seen !== 3'b010) begin
            errors++;
            $display("FAIL timeout_waitld: got to/err/done=%b mask=%b want 110 010",
                     {timeout_o, error_o, done_o}, pre_seen);
        end
        clear_plan();
        ev_p[TO] = 1'b1;     ed_p[TO] = 32'h0000_0003;
        ev_p[TO + 2] = 1'b1; ed_p[TO + 2] = 32'h0000_0005;
        for (int m = T1 + 1; m < TO; m += 7) begin
            ev_p[m] = 1'b1; ed_p[m] = 32'hABCD_0000 | 32'(m << 1);
        end
        run_scenario(2'd2, 2'd0, 0, 1'b1);
        checks++;
        if ({timeout_o, error_o, done_o} !== 3'b110 || exit_code_o !== 32'd0) begin
            errors++;
            $display("FAIL timeout_priority: got to/err/done=%b exit=%h want 110 0",
                     {timeout_o, error_o, done_o}, exit_code_o);
        end
    endtask

    task automatic test_reset_mid_pwrup();
        clear_plan();
        run_scenario(2'd2, 2'd0, RST + 10, 1'b1);
        clear_plan();
        ev_p[T1 + 4] = 1'b1; ed_p[T1 + 4] = 32'h0000_0021;
        run_scenario(2'd2, 2'd0, 0, 1'b0);
        checks++;
        if (done_o !== 1'b1 || exit_code_o !== 32'h10 || n_prog !== ITVS) begin
            errors++;
            $display("FAIL restart_after_reset: got done=%b exit=%h progress=%0d want 1 10 %0d",
                     done_o, exit_code_o, n_prog, ITVS);
        end
    endtask

    task automatic test_random();
        logic [1:0] bm;
        logic [1:0] pm;
        for (int r = 0; r < 12; r++) begin
            clear_plan();
            bm = 2'($urandom_range(0, 3));
            pm = 2'($urandom_range(0, 3));
            for (int n = 1; n <= NMAX; n++) begin
                ld_p[n] = ($urandom_range(0, 14) == 0);
                ev_p[n] = ($urandom_range(0, 9) == 0);
                ed_p[n] = $urandom;
                st_p[n] = ($urandom_range(0, 19) == 0);
            end
            run_scenario(bm, pm, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_preload_jtag();
        test_autonomous();
        test_sd_error();
        test_preload_modes();
        test_timeout();
        test_reset_mid_pwrup();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
